// File: rtl/stopwatch_ctrl.sv
// Four-digit BCD stopwatch with start/stop, clear, lap freeze and a wrap flag,
// plus a one-hot digit scanner for a multiplexed seven-segment display.
module stopwatch_ctrl #(
  parameter int unsigned PRESCALE = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] disp,
  output logic [3:0]  scan_sel,
  output logic [3:0]  scan_bcd,
  output logic        running,
  output logic        lap_active,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);
  localparam logic [15:0] COUNT_MAX = 16'h9999;

  state_e      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] count_q, count_d;
  logic [15:0] freeze_q, freeze_d;
  logic        lap_q, lap_d;
  logic        ovf_q, ovf_d;
  logic        running_q, running_d;
  logic [3:0]  scan_q;
  logic        tick;

  // Increment a packed 4-digit BCD value; a digit at 9 wraps to 0 and carries.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_stop && !clear) state_d = RUN;
      RUN:     if (start_stop) state_d = STOP;
      STOP: begin
        if (clear)           state_d = IDLE;
        else if (start_stop) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tick = (state_q == RUN) && (presc_q == PRESC_MAX);

  always_comb begin
    presc_d   = presc_q;
    count_d   = count_q;
    freeze_d  = freeze_q;
    lap_d     = lap_q;
    ovf_d     = ovf_q;
    running_d = (state_d == RUN);

    if (state_q == RUN) begin
      presc_d = tick ? 16'd0 : presc_q + 16'd1;
      if (tick) begin
        count_d = bcd_inc(count_q);
        if (count_q == COUNT_MAX) ovf_d = 1'b1;
      end
      // Freeze captures count_q, i.e. the pre-increment value on a tick edge.
      if (lap) begin
        if (lap_q) begin
          lap_d = 1'b0;
        end else begin
          lap_d    = 1'b1;
          freeze_d = count_q;
        end
      end
    end else if (lap) begin
      lap_d = 1'b0;
    end

    if (state_d == IDLE) begin
      presc_d = 16'd0;
      count_d = 16'd0;
      ovf_d   = 1'b0;
      lap_d   = 1'b0;
    end
  end

  // NOTE: the freeze register is a plain register, so it is reset along with
  // the rest of the datapath rather than left undefined.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q   <= 16'd0;
      count_q   <= 16'd0;
      freeze_q  <= 16'd0;
      lap_q     <= 1'b0;
      ovf_q     <= 1'b0;
      running_q <= 1'b0;
      scan_q    <= 4'b0001;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      freeze_q  <= freeze_d;
      lap_q     <= lap_d;
      ovf_q     <= ovf_d;
      running_q <= running_d;
      scan_q    <= {scan_q[2:0], scan_q[3]};
    end
  end

  assign disp       = lap_q ? freeze_q : count_q;
  assign scan_sel   = scan_q;
  assign running    = running_q;
  assign lap_active = lap_q;
  assign ovf        = ovf_q;

  always_comb begin
    scan_bcd = 4'd0;
    case (scan_q)
      4'b0001: scan_bcd = disp[3:0];
      4'b0010: scan_bcd = disp[7:4];
      4'b0100: scan_bcd = disp[11:8];
      4'b1000: scan_bcd = disp[15:12];
      default: scan_bcd = 4'd0;
    endcase
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at PRESCALE=2: run/stop, resume latency,
// lap freeze, clear priority, scan rotation, 9999 wrap and mid-count reset.
module tb_stopwatch_ctrl;

  logic        clk;
  logic        reset;
  logic        start_stop;
  logic        clear;
  logic        lap;
  logic [15:0] disp;
  logic [3:0]  scan_sel;
  logic [3:0]  scan_bcd;
  logic        running;
  logic        lap_active;
  logic        ovf;

  int n_checks = 0;
  int n_pass   = 0;

  stopwatch_ctrl #(.PRESCALE(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .disp       (disp),
    .scan_sel   (scan_sel),
    .scan_bcd   (scan_bcd),
    .running    (running),
    .lap_active (lap_active),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle pulse on the selected inputs, sampled by the next edge.
  task automatic pulse(input logic ss, input logic cl, input logic lp);
    start_stop = ss;
    clear      = cl;
    lap        = lp;
    @(posedge clk);
    #1;
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
  endtask

  initial begin
    logic       found;
    logic [3:0] exp_sel [4];
    logic [3:0] exp_bcd [4];
    exp_sel = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_bcd = '{4'd4, 4'd3, 4'd2, 4'd1};

    reset      = 1'b0;
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
    #12;
    check("rst_disp",     disp,       16'h0000);
    check("rst_running",  running,    1'b0);
    check("rst_lap",      lap_active, 1'b0);
    check("rst_ovf",      ovf,        1'b0);
    check("rst_scan_sel", scan_sel,   4'b0001);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Ten ticks in twenty clocks.
    pulse(1, 0, 0);
    step(20);
    check("run20_disp",    disp,    16'h0010);
    check("run20_running", running, 1'b1);

    // Stop holds the count; prescaler held at 1 gives a one-clock resume.
    pulse(1, 0, 0);
    step(10);
    check("stop_disp",    disp,    16'h0010);
    check("stop_running", running, 1'b0);
    pulse(1, 0, 0);
    check("resume_edge_disp", disp,    16'h0010);
    check("resume_running",   running, 1'b1);
    step(1);
    check("resume_1clk_disp", disp, 16'h0011);

    // Clear beats start_stop in STOP, and in IDLE.
    pulse(1, 0, 0);
    pulse(1, 1, 0);
    check("clr_stop_disp",    disp,    16'h0000);
    check("clr_stop_running", running, 1'b0);
    pulse(1, 1, 0);
    step(4);
    check("clr_idle_running", running, 1'b0);
    check("clr_idle_disp",    disp,    16'h0000);

    // Lap freeze and release.
    pulse(1, 0, 0);
    step(10);
    check("lap_pre_disp", disp, 16'h0005);
    pulse(0, 0, 1);
    check("lap_on_active", lap_active, 1'b1);
    step(9);
    check("lap_frozen_disp", disp, 16'h0005);
    pulse(0, 0, 1);
    check("lap_off_disp",   disp,       16'h0010);
    check("lap_off_active", lap_active, 1'b0);
    // Lap on a tick edge freezes the pre-increment count.
    pulse(0, 0, 1);
    check("lap_tick_disp", disp, 16'h0010);
    pulse(0, 0, 1);
    check("lap_tick_live", disp, 16'h0011);
    // Stopping keeps lap active; lap in STOP releases it without reload.
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    check("stop_lap_active",  lap_active, 1'b1);
    check("stop_lap_running", running,    1'b0);
    check("stop_lap_disp",    disp,       16'h0011);
    pulse(0, 0, 1);
    check("stop_lapoff_active", lap_active, 1'b0);
    check("stop_lapoff_disp",   disp,       16'h0012);
    // Clear is ignored while running.
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    check("run_clr_running", running, 1'b1);
    check("run_clr_disp",    disp,    16'h0013);

    // Scan rotation over a stopped 1234.
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    step(2468);
    pulse(1, 0, 0);
    check("scan_disp", disp, 16'h1234);
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      if (scan_sel == 4'b0001) found = 1'b1;
      else step(1);
    end
    check("scan_align", found, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("scan_sel_%0d", i), scan_sel, exp_sel[i]);
      check($sformatf("scan_bcd_%0d", i), scan_bcd, exp_bcd[i]);
      step(1);
    end

    // 9999 wrap sets a sticky ovf; only IDLE clears it.
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    step(19998);
    check("pre_wrap_disp", disp, 16'h9999);
    check("pre_wrap_ovf",  ovf,  1'b0);
    step(2);
    check("wrap_disp", disp, 16'h0000);
    check("wrap_ovf",  ovf,  1'b1);
    pulse(1, 0, 0);
    check("wrap_stop_ovf", ovf, 1'b1);
    pulse(0, 1, 0);
    check("wrap_clr_ovf",  ovf,  1'b0);
    check("wrap_clr_disp", disp, 16'h0000);

    // Asynchronous reset in mid-count discards all progress.
    pulse(1, 0, 0);
    step(6);
    check("mid_disp", disp, 16'h0003);
    reset = 1'b0;
    #1;
    check("mid_rst_disp",     disp,     16'h0000);
    check("mid_rst_running",  running,  1'b0);
    check("mid_rst_scan_sel", scan_sel, 4'b0001);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(4);
    check("post_rst_disp",    disp,    16'h0000);
    check("post_rst_running", running, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter PRESCALE, default 10: clk cycles per count tick; legal range 2..65535.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low. Ports are named clk and reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous active-low reset.
REQ-005 start_stop  input  1  one-cycle pulse; toggles run/stop.
REQ-006 clear  input  1  one-cycle pulse; returns a stopped count to zero.
REQ-007 lap  input  1  one-cycle pulse; toggles display freeze while running.
REQ-008 disp  output  16  four BCD digits, [15:12] most significant; shows the live count, or the frozen value while lap is active.
REQ-009 scan_sel  output  4  one-hot digit strobe, rotating 0001->0010->0100->1000->0001, one step per clk.
REQ-010 scan_bcd  output  4  the disp digit selected by scan_sel (bit0 selects [3:0]).
REQ-011 running  output  1  high in RUN.
REQ-012 lap_active  output  1  high while the display is frozen.
REQ-013 ovf  output  1  sticky flag for a 9999->0000 wrap.

Function
REQ-014 The FSM SHALL have three states, IDLE, RUN and STOP, and evaluate inputs on every rising clk edge.
REQ-015 IDLE: start_stop -> RUN, with the prescaler cleared to 0; clear has priority over a simultaneous start_stop, and the state stays IDLE.
REQ-016 RUN: start_stop -> STOP; clear is ignored.
REQ-017 STOP: clear -> IDLE (priority over a simultaneous start_stop); otherwise start_stop -> RUN.
REQ-018 Prescaler: counts 0..PRESCALE-1 only in RUN and holds its value in STOP; tick = RUN and prescaler == PRESCALE-1; on a tick it wraps to 0.
REQ-019 Count: 4-digit BCD; increments by 1 on the tick edge; a digit at 9 goes to 0 and carries into the next digit; no digit ever holds a value above 9.
REQ-020 Latency: the first increment lands PRESCALE cycles after the edge that enters RUN from IDLE; resuming from STOP continues from the held prescaler value.
REQ-021 Wrap: on 9999 + tick the count becomes 0000 and ovf is set; ovf stays set until IDLE is entered or reset is asserted.
REQ-022 Entering IDLE SHALL zero the count and the prescaler, clear ovf and clear lap_active.
REQ-023 Lap in RUN: when lap_active=0, a lap pulse copies the live count into the freeze register and sets lap_active; when lap_active=1, a lap pulse clears lap_active. Counting continues either way.
REQ-024 Lap in STOP or IDLE clears lap_active and does not reload the freeze register.
REQ-025 If a tick and a lap pulse occur on the same edge, the freeze register captures the pre-increment count.
REQ-026 start_stop in RUN with lap_active=1 keeps lap_active=1.
REQ-027 disp = lap_active ? freeze register : live count.
REQ-028 scan_sel and scan_bcd rotate every cycle in all states; scan_bcd is combinational from scan_sel and disp.
REQ-029 running, lap_active and ovf SHALL be registered outputs.

Reset
REQ-030 reset=0 SHALL immediately force: state IDLE; count 0000; freeze register 0000; prescaler 0; ovf 0; lap_active 0; running 0; scan_sel 0001.
REQ-031 Reset asserted in mid-count SHALL discard all progress; counting resumes only after reset=1 and a start_stop pulse.

Verification (PRESCALE=2)
REQ-032 Reset, one start_stop pulse, 20 clks -> disp=0x0010, running=1.
REQ-033 RUN, start_stop, 10 idle clks -> disp unchanged, running=0; start_stop -> next increment after 1 or 2 clks, per the held prescaler value.
REQ-034 Preload the count to 9999 via 19998 clks -> the next tick gives disp=0x0000, ovf=1; stop then clear -> ovf=0, disp=0x0000.
REQ-035 At disp=0x0005, a lap pulse, then 10 clks -> disp=0x0005 while the live count reaches 0x0010; a second lap pulse -> disp=0x0010.
REQ-036 In STOP, simultaneous clear and start_stop -> IDLE, count 0000, running=0; clear pulse in RUN -> no effect.
REQ-037 With disp=0x1234, observe 4 clks -> scan_bcd sequence 4,3,2,1 paired with scan_sel 0001,0010,0100,1000.
